// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: control-bit indices and memory-stage FSM encodings
package memory_stage_pkg;
  localparam int I_MEM_R = 0;
  localparam int I_MEM_W = 1;
  localparam int I_LW    = 2;
  localparam int I_LB    = 3;
  localparam int I_LBU   = 4;
  localparam int I_LH    = 5;
  localparam int I_LHU   = 6;
  localparam int I_LWL   = 7;
  localparam int I_LWR   = 8;
  localparam int I_MAX   = 9;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_HOLD = 2'd2
  } ms_state_e;
endpackage

// File: rtl/memory_stage_load_align.sv
// memory_stage_load_align: extracts byte/half/word and merges LWL/LWR from a returned data word
module memory_stage_load_align
  import memory_stage_pkg::*;
(
  input  logic [I_MAX-1:0] i_ctrl,
  input  logic [31:0]      i_w,
  input  logic [31:0]      i_rdata2,
  input  logic [31:0]      i_result,
  input  logic [1:0]       i_off,
  output logic [31:0]      o_data
);
  logic [5:0]  w_sh;
  logic [31:0] w_dn;
  logic [31:0] w_lwl_mask;
  logic [31:0] w_lwr_mask;

  assign w_sh       = {1'b0, i_off, 3'b000};
  assign w_dn       = i_w >> w_sh;
  assign w_lwl_mask = 32'hffffffff >> (w_sh + 6'd8);
  assign w_lwr_mask = ~(32'hffffffff >> w_sh);

  // stores and non-loads keep the execute result; loads pick their extraction
  always_comb begin
    o_data = (!i_ctrl[I_MEM_R] || i_ctrl[I_MEM_W]) ? i_result
           : i_ctrl[I_LB]  ? {{24{w_dn[7]}}, w_dn[7:0]}
           : i_ctrl[I_LBU] ? {24'd0, w_dn[7:0]}
           : i_ctrl[I_LH]  ? {{16{w_dn[15]}}, w_dn[15:0]}
           : i_ctrl[I_LHU] ? {16'd0, w_dn[15:0]}
           : i_ctrl[I_LWL] ? (i_w << (6'd24 - w_sh)) | (i_rdata2 & w_lwl_mask)
           : i_ctrl[I_LWR] ? w_dn | (i_rdata2 & w_lwr_mask)
           : i_ctrl[I_LW]  ? i_w
           : i_result;
  end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: waits for data-bus responses, aligns load data and registers results toward writeback.
// Optional forwarding port enabled by defining MEM_STAGE_FWD_EN; otherwise forwarding outputs are tied to zero.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_data_ok,
  input  logic [31:0]      data_rdata,
  output logic [4:0]       mem_fwd_addr,
  output logic [31:0]      mem_fwd_data,
  output logic             mem_fwd_ok,
  output logic             ready_o,
  input  logic             valid_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      inst_i,
  input  logic [I_MAX-1:0] ctrl_i,
  input  logic [31:0]      result_i,
  input  logic [31:0]      eaddr_i,
  input  logic [31:0]      rdata2_i,
  input  logic [4:0]       waddr_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      inst_o,
  output logic [I_MAX-1:0] ctrl_o,
  output logic [31:0]      result_o,
  output logic [4:0]       waddr_o
);
  ms_state_e   r_state;
  ms_state_e   w_next;
  logic [31:0] r_buf;
  logic [31:0] w_word;
  logic [31:0] w_result;
  logic        w_mem;
  logic        w_data;
  logic        w_take;
  logic        w_load;
  logic        w_unused;

  assign w_mem    = valid_i & (ctrl_i[I_MEM_R] | ctrl_i[I_MEM_W]);
  assign w_take   = data_data_ok & ((r_state == MS_WAIT) | ((r_state == MS_IDLE) & w_mem));
  assign w_data   = (r_state == MS_HOLD) | w_take;
  assign w_word   = (r_state == MS_HOLD) ? r_buf : data_rdata;
  assign w_load   = ready_i & (((r_state == MS_IDLE) & !w_mem) | w_data);
  assign ready_o  = (r_state == MS_IDLE) & (ready_i | !valid_i) & !(w_mem & !(data_data_ok & ready_i));
  assign w_unused = ^eaddr_i[31:2];

  memory_stage_load_align u_align (
    .i_ctrl   (ctrl_i),
    .i_w      (w_word),
    .i_rdata2 (rdata2_i),
    .i_result (result_i),
    .i_off    (eaddr_i[1:0]),
    .o_data   (w_result)
  );

  // next state: wait for the response, then park it in HOLD until downstream accepts
  always_comb begin
    w_next = r_state;
    w_next = (r_state == MS_HOLD) ? (ready_i ? MS_IDLE : MS_HOLD)
           : ((r_state == MS_WAIT) || w_mem) ? (!data_data_ok ? MS_WAIT : ready_i ? MS_IDLE : MS_HOLD)
           : MS_IDLE;
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= MS_IDLE;
    else         r_state <= w_next;
  end

  // capture the response word so it survives a downstream stall
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     r_buf <= '0;
    else if (w_take) r_buf <= data_rdata;
  end

  // output registers: load on completion, bubble when downstream drains, else hold
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_o  <= 1'b0;
      pc_o     <= '0;
      inst_o   <= '0;
      ctrl_o   <= '0;
      result_o <= '0;
      waddr_o  <= '0;
    end else if (w_load) begin
      valid_o  <= (r_state == MS_IDLE) ? valid_i : 1'b1;
      pc_o     <= pc_i;
      inst_o   <= inst_i;
      ctrl_o   <= ctrl_i;
      result_o <= w_result;
      waddr_o  <= waddr_i;
    end else if (ready_i) begin
      valid_o  <= 1'b0;
    end
  end

`ifdef MEM_STAGE_FWD_EN
  assign mem_fwd_addr = valid_o ? waddr_o : 5'd0;
  assign mem_fwd_data = result_o;
  assign mem_fwd_ok   = valid_o;
`else
  assign mem_fwd_addr = 5'd0;
  assign mem_fwd_data = 32'd0;
  assign mem_fwd_ok   = 1'b0;
`endif
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: vector table, hand-written stall/reset sequences and a randomized run against a transaction-level model
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             data_data_ok = 1'b0;
  logic [31:0]      data_rdata = '0;
  logic [4:0]       mem_fwd_addr;
  logic [31:0]      mem_fwd_data;
  logic             mem_fwd_ok;
  logic             ready_o;
  logic             valid_i = 1'b0;
  logic [31:0]      pc_i = '0;
  logic [31:0]      inst_i = '0;
  logic [I_MAX-1:0] ctrl_i = '0;
  logic [31:0]      result_i = '0;
  logic [31:0]      eaddr_i = '0;
  logic [31:0]      rdata2_i = '0;
  logic [4:0]       waddr_i = '0;
  logic             ready_i = 1'b0;
  logic             valid_o;
  logic [31:0]      pc_o;
  logic [31:0]      inst_o;
  logic [I_MAX-1:0] ctrl_o;
  logic [31:0]      result_o;
  logic [4:0]       waddr_o;

  int passed = 0;
  int total  = 0;

  typedef enum int {OP_ALU, OP_SW, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LWL, OP_LWR} op_e;

  typedef struct {
    op_e         op;
    logic [31:0] eaddr;
    logic [31:0] rdata;
    logic [31:0] rdata2;
    logic [31:0] result;
    logic [4:0]  waddr;
    logic [31:0] exp;
  } vec_t;

  memory_stage dut (
    .clk(clk), .resetn(resetn), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data), .mem_fwd_ok(mem_fwd_ok),
    .ready_o(ready_o), .valid_i(valid_i), .pc_i(pc_i), .inst_i(inst_i), .ctrl_i(ctrl_i),
    .result_i(result_i), .eaddr_i(eaddr_i), .rdata2_i(rdata2_i), .waddr_i(waddr_i),
    .ready_i(ready_i), .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .ctrl_o(ctrl_o),
    .result_o(result_o), .waddr_o(waddr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [I_MAX-1:0] ctrl_of(op_e op);
    logic [I_MAX-1:0] c;
    c = '0;
    case (op)
      OP_SW:   c[I_MEM_W] = 1'b1;
      OP_LW:   begin c[I_MEM_R] = 1'b1; c[I_LW]  = 1'b1; end
      OP_LB:   begin c[I_MEM_R] = 1'b1; c[I_LB]  = 1'b1; end
      OP_LBU:  begin c[I_MEM_R] = 1'b1; c[I_LBU] = 1'b1; end
      OP_LH:   begin c[I_MEM_R] = 1'b1; c[I_LH]  = 1'b1; end
      OP_LHU:  begin c[I_MEM_R] = 1'b1; c[I_LHU] = 1'b1; end
      OP_LWL:  begin c[I_MEM_R] = 1'b1; c[I_LWL] = 1'b1; end
      OP_LWR:  begin c[I_MEM_R] = 1'b1; c[I_LWR] = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // byte-lane reference: LWL fills the top (off+1) lanes from memory, LWR fills the bottom (4-off) lanes
  function automatic logic [31:0] ref_result(op_e op, logic [31:0] w, logic [31:0] rd2,
                                             logic [31:0] res, logic [1:0] off);
    logic [7:0]  b [4];
    logic [7:0]  r [4];
    logic [31:0] o;
    int n;
    n = int'(off);
    for (int i = 0; i < 4; i++) begin
      b[i] = w[8*i +: 8];
      r[i] = rd2[8*i +: 8];
    end
    o = '0;
    case (op)
      OP_LW:  o = w;
      OP_LB:  o = {{24{b[n][7]}}, b[n]};
      OP_LBU: o = {24'd0, b[n]};
      OP_LH:  o = {{16{b[n+1][7]}}, b[n+1], b[n]};
      OP_LHU: o = {16'd0, b[n+1], b[n]};
      OP_LWL: for (int i = 0; i < 4; i++)
                if (i >= 3 - n) o[8*i +: 8] = b[i-3+n];
                else            o[8*i +: 8] = r[i];
      OP_LWR: for (int i = 0; i < 4; i++)
                if (i <= 3 - n) o[8*i +: 8] = b[i+n];
                else            o[8*i +: 8] = r[i];
      default: o = res;
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_out(input string n, input logic ev, input logic [31:0] er, input logic [4:0] ew);
    chk({n, "_valid"}, 32'(valid_o), 32'(ev));
    if (ev) begin
      chk({n, "_result"}, result_o, er);
      chk({n, "_waddr"}, 32'(waddr_o), 32'(ew));
    end
`ifdef MEM_STAGE_FWD_EN
    chk({n, "_fwd_ok"}, 32'(mem_fwd_ok), 32'(ev));
    chk({n, "_fwd_addr"}, 32'(mem_fwd_addr), ev ? 32'(ew) : 32'd0);
    if (ev) chk({n, "_fwd_data"}, mem_fwd_data, er);
`else
    chk({n, "_fwd_ok"}, 32'(mem_fwd_ok), 32'd0);
    chk({n, "_fwd_addr"}, 32'(mem_fwd_addr), 32'd0);
    chk({n, "_fwd_data"}, mem_fwd_data, 32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input op_e op, input logic [31:0] ea, input logic [31:0] rd2,
                         input logic [31:0] res, input logic [4:0] wa, input logic [31:0] pc);
    valid_i  = 1'b1;
    ctrl_i   = ctrl_of(op);
    eaddr_i  = ea;
    rdata2_i = rd2;
    result_i = res;
    waddr_i  = wa;
    pc_i     = pc;
    inst_i   = ~pc;
  endtask

  vec_t tv [13];

  op_e         cur_op;
  logic [31:0] cur_ea, cur_rd2, cur_res, cur_pc, wsave;
  logic [4:0]  cur_wa;
  logic        have, got, mem, cmp, exp_valid;
  logic [31:0] exp_res, exp_pc;
  logic [4:0]  exp_wa;
  int          k, d;

  initial begin
    tv[0]  = '{OP_ALU, 32'h0,  32'h0,        32'h0,        32'h1234,     5'd5,  32'h0000_1234};
    tv[1]  = '{OP_LB,  32'h13, 32'h80FF_FFFF, 32'h0,       32'h0,        5'd6,  32'hFFFF_FF80};
    tv[2]  = '{OP_LBU, 32'h13, 32'h80FF_FFFF, 32'h0,       32'h0,        5'd7,  32'h0000_0080};
    tv[3]  = '{OP_LWL, 32'h21, 32'hAABB_CCDD, 32'h1122_3344, 32'h0,      5'd8,  32'hCCDD_3344};
    tv[4]  = '{OP_LWR, 32'h21, 32'hAABB_CCDD, 32'h1122_3344, 32'h0,      5'd9,  32'h11AA_BBCC};
    tv[5]  = '{OP_LH,  32'h42, 32'h8001_7FFF, 32'h0,       32'h0,        5'd10, 32'hFFFF_8001};
    tv[6]  = '{OP_LHU, 32'h42, 32'h8001_7FFF, 32'h0,       32'h0,        5'd11, 32'h0000_8001};
    tv[7]  = '{OP_LH,  32'h40, 32'h1234_8765, 32'h0,       32'h0,        5'd12, 32'hFFFF_8765};
    tv[8]  = '{OP_LW,  32'h80, 32'hDEAD_BEEF, 32'h0,       32'h0,        5'd13, 32'hDEAD_BEEF};
    tv[9]  = '{OP_SW,  32'h84, 32'h0000_0005, 32'h0,       32'hCAFE_0001, 5'd0, 32'hCAFE_0001};
    tv[10] = '{OP_LWL, 32'h23, 32'hAABB_CCDD, 32'h1122_3344, 32'h0,      5'd14, 32'hAABB_CCDD};
    tv[11] = '{OP_LWL, 32'h20, 32'hAABB_CCDD, 32'h1122_3344, 32'h0,      5'd15, 32'hDD22_3344};
    tv[12] = '{OP_LWR, 32'h23, 32'hAABB_CCDD, 32'h1122_3344, 32'h0,      5'd16, 32'h1122_33AA};

    // reset state
    tick();
    tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_ctrl", 32'(ctrl_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_waddr", 32'(waddr_o), 32'd0);
    chk("rst_fwd_ok", 32'(mem_fwd_ok), 32'd0);
    resetn = 1'b1;
    ready_i = 1'b1;
    #1 chk("rst_ready", 32'(ready_o), 32'd1);

    // single-cycle vectors: data returned in the same cycle, downstream ready
    for (int i = 0; i < 13; i++) begin
      present(tv[i].op, tv[i].eaddr, tv[i].rdata2, tv[i].result, tv[i].waddr, 32'h100 + 32'(i));
      data_rdata   = tv[i].rdata;
      data_data_ok = tv[i].op != OP_ALU;
      ready_i      = 1'b1;
      #1 chk($sformatf("tv%0d_ready", i), 32'(ready_o), 32'd1);
      tick();
      chk_out($sformatf("tv%0d", i), 1'b1, tv[i].exp, tv[i].waddr);
      chk($sformatf("tv%0d_pc", i), pc_o, 32'h100 + 32'(i));
      valid_i = 1'b0;
      data_data_ok = 1'b0;
    end

    // LW answered three cycles late
    present(OP_LW, 32'h200, 32'h0, 32'h0, 5'd3, 32'h300);
    ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("late_ready%0d", c), 32'(ready_o), 32'd0);
      tick();
      chk($sformatf("late_valid%0d", c), 32'(valid_o), 32'd0);
    end
    data_data_ok = 1'b1;
    data_rdata = 32'hDEAD_BEEF;
    #1 chk("late_ready_dok", 32'(ready_o), 32'd0);
    tick();
    chk_out("late_done", 1'b1, 32'hDEAD_BEEF, 5'd3);
    valid_i = 1'b0;
    data_data_ok = 1'b0;
    ready_i = 1'b0;
    #1 chk("late_idle_ready", 32'(ready_o), 32'd1);

    // response lands while downstream stalls; bus data changes before release
    present(OP_LWR, 32'h402, 32'hA5A5_A5A5, 32'h0, 5'd17, 32'h400);
    tick();
    data_data_ok = 1'b1;
    data_rdata = 32'h1357_9BDF;
    #1 chk("hold_ready_dok", 32'(ready_o), 32'd0);
    tick();
    data_data_ok = 1'b0;
    data_rdata = 32'hFFFF_FFFF;
    chk_out("hold_keep1", 1'b1, 32'hDEAD_BEEF, 5'd3);
    tick();
    data_rdata = 32'h0;
    chk_out("hold_keep2", 1'b1, 32'hDEAD_BEEF, 5'd3);
    #1 chk("hold_ready", 32'(ready_o), 32'd0);
    ready_i = 1'b1;
    tick();
    chk_out("hold_done", 1'b1, 32'hA5A5_1357, 5'd17);
    valid_i = 1'b0;

    // asynchronous reset while waiting for a response
    present(OP_ALU, 32'h0, 32'h0, 32'h77, 5'd9, 32'h500);
    tick();
    present(OP_LW, 32'h600, 32'h0, 32'h0, 5'd4, 32'h504);
    ready_i = 1'b0;
    tick();
    chk_out("wait_keep", 1'b1, 32'h77, 5'd9);
    #2 resetn = 1'b0;
    valid_i = 1'b0;
    #1 chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_result", result_o, 32'd0);
    chk("arst_fwd_ok", 32'(mem_fwd_ok), 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd1);
    tick();
    resetn = 1'b1;
    ready_i = 1'b1;
    data_data_ok = 1'b1;
    data_rdata = 32'h5555_AAAA;
    #1 chk("stray_ready", 32'(ready_o), 32'd1);
    tick();
    data_data_ok = 1'b0;
    chk("stray_valid", 32'(valid_o), 32'd0);
    present(OP_ALU, 32'h0, 32'h0, 32'h99, 5'd2, 32'h700);
    #1 chk("post_rst_ready", 32'(ready_o), 32'd1);
    tick();
    chk_out("post_rst", 1'b1, 32'h99, 5'd2);
    valid_i = 1'b0;
    tick();
    chk("post_rst_drain", 32'(valid_o), 32'd0);

    // randomized traffic: an instruction completes at the first cycle with data available and ready_i high
    have = 1'b0;
    got = 1'b0;
    exp_valid = 1'b0;
    exp_res = '0;
    exp_pc = '0;
    exp_wa = '0;
    k = 0;
    d = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk("rnd_valid", 32'(valid_o), 32'(exp_valid));
      if (exp_valid) begin
        chk("rnd_result", result_o, exp_res);
        chk("rnd_waddr", 32'(waddr_o), 32'(exp_wa));
        chk("rnd_pc", pc_o, exp_pc);
      end
      if (!have && $urandom_range(0, 2) != 0) begin
        have    = 1'b1;
        got     = 1'b0;
        k       = 0;
        d       = int'($urandom_range(0, 3));
        cur_op  = op_e'($urandom_range(0, 8));
        cur_ea  = $urandom;
        if (cur_op == OP_LH || cur_op == OP_LHU) cur_ea[0] = 1'b0;
        cur_rd2 = $urandom;
        cur_res = $urandom;
        cur_wa  = 5'($urandom);
        cur_pc  = $urandom;
      end
      mem = have && cur_op != OP_ALU;
      ready_i = $urandom_range(0, 3) != 0;
      data_rdata = $urandom;
      data_data_ok = mem ? (k == d) : (have ? 1'b0 : ($urandom_range(0, 3) == 0));
      if (have) present(cur_op, cur_ea, cur_rd2, cur_res, cur_wa, cur_pc);
      else begin
        valid_i = 1'b0;
        ctrl_i = I_MAX'($urandom);
        result_i = $urandom;
      end
      if (mem && data_data_ok) begin
        wsave = data_rdata;
        got = 1'b1;
      end
      #1 chk("rnd_ready", 32'(ready_o),
             32'(!have ? 1'b1 : !mem ? ready_i : (k == 0 && data_data_ok && ready_i)));
      cmp = have && ready_i && (!mem || got);
      if (cmp) begin
        exp_valid = 1'b1;
        exp_res = ref_result(cur_op, wsave, cur_rd2, cur_res, cur_ea[1:0]);
        exp_wa = cur_wa;
        exp_pc = cur_pc;
        have = 1'b0;
      end else if (ready_i) exp_valid = 1'b0;
      k++;
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
